// File: rtl/wb_writer_if.sv
// Bus bundle for the writeback stage: MEM handshake, memory response and register-file write port.
// RetireCnt_o_WB exists only when WB_RETIRE_CNT_EN is defined.
interface wb_writer_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  Valid_i_WB;
  logic                  Ready_o_WB;
  logic                  WrEn_i_WB;
  logic [REG_ADDR_W-1:0] WrAddr_i_WB;
  logic [XLEN-1:0]       AluData_i_WB;
  logic                  IsLoad_i_WB;
  logic [2:0]            LoadFunct3_i_WB;
  logic [1:0]            LoadAddrLow_i_WB;
  logic                  MemRspValid_i_WB;
  logic [XLEN-1:0]       MemRspData_i_WB;
  logic                  WrEn_o_WB;
  logic [REG_ADDR_W-1:0] WrAddr_o_WB;
  logic [XLEN-1:0]       WrData_o_WB;
  logic [REG_ADDR_W-1:0] fWB_Addr_o_WB;
  logic [XLEN-1:0]       fWB_Data_o_WB;
  logic                  LoadTimeout_o_WB;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0]           RetireCnt_o_WB;
`endif

  // slave: the writeback stage itself
  modport slave (
    input  Valid_i_WB, WrEn_i_WB, WrAddr_i_WB, AluData_i_WB, IsLoad_i_WB,
           LoadFunct3_i_WB, LoadAddrLow_i_WB, MemRspValid_i_WB, MemRspData_i_WB,
    output Ready_o_WB, WrEn_o_WB, WrAddr_o_WB, WrData_o_WB,
           fWB_Addr_o_WB, fWB_Data_o_WB, LoadTimeout_o_WB
`ifdef WB_RETIRE_CNT_EN
    , output RetireCnt_o_WB
`endif
  );

  // master: MEM stage / memory / register file side
  modport master (
    output Valid_i_WB, WrEn_i_WB, WrAddr_i_WB, AluData_i_WB, IsLoad_i_WB,
           LoadFunct3_i_WB, LoadAddrLow_i_WB, MemRspValid_i_WB, MemRspData_i_WB,
    input  Ready_o_WB, WrEn_o_WB, WrAddr_o_WB, WrData_o_WB,
           fWB_Addr_o_WB, fWB_Data_o_WB, LoadTimeout_o_WB
`ifdef WB_RETIRE_CNT_EN
    , input RetireCnt_o_WB
`endif
  );
endinterface

// File: rtl/wb_writer.sv
// Writeback stage: retires MEM instructions, waits for load responses, issues one write pulse per rd write.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
//
// state    | meaning
// IDLE     | ready for a retiring instruction; non-loads write next cycle
// WAIT_RSP | load accepted, waiting for the memory response or the timeout
module wb_writer #(
  parameter int XLEN        = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int RSP_TIMEOUT = 16
) (
  input logic       clk_i_WB,
  input logic       Rst_i_WB,
  wb_writer_if.slave bus
);

  localparam int CNT_W = (RSP_TIMEOUT > 2) ? $clog2(RSP_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  wr_en, wr_en_nxt;
  logic [REG_ADDR_W-1:0] wr_addr, wr_addr_nxt;
  logic [XLEN-1:0]       wr_data, wr_data_nxt;
  logic                  timeout, timeout_nxt;
  logic                  capture;

  logic                  ld_wr_en;
  logic [REG_ADDR_W-1:0] ld_addr;
  logic [2:0]            ld_funct3;
  logic [1:0]            ld_low;

  function automatic logic [XLEN-1:0] extract(
    input logic [2:0]      funct3,
    input logic [1:0]      low,
    input logic [XLEN-1:0] word
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{low, 3'b000} +: 8];
    h = word[{low[1], 4'b0000} +: 16];
    case (funct3)
      3'b000:  extract = {{(XLEN-8){b[7]}}, b};
      3'b100:  extract = {{(XLEN-8){1'b0}}, b};
      3'b001:  extract = {{(XLEN-16){h[15]}}, h};
      3'b101:  extract = {{(XLEN-16){1'b0}}, h};
      default: extract = word;
    endcase
  endfunction

  always_ff @(posedge clk_i_WB) begin
    if (Rst_i_WB) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      timeout   <= 1'b0;
      ld_wr_en  <= 1'b0;
      ld_addr   <= '0;
      ld_funct3 <= '0;
      ld_low    <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wr_en   <= wr_en_nxt;
      wr_addr <= wr_addr_nxt;
      wr_data <= wr_data_nxt;
      timeout <= timeout_nxt;
      if (capture) begin
        ld_wr_en  <= bus.WrEn_i_WB;
        ld_addr   <= bus.WrAddr_i_WB;
        ld_funct3 <= bus.LoadFunct3_i_WB;
        ld_low    <= bus.LoadAddrLow_i_WB;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr;
    wr_data_nxt = wr_data;
    timeout_nxt = 1'b0;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Valid_i_WB) begin
          if (bus.IsLoad_i_WB) begin
            capture   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = WAIT_RSP;
          end else begin
            wr_en_nxt   = bus.WrEn_i_WB && (bus.WrAddr_i_WB != '0);
            wr_addr_nxt = bus.WrAddr_i_WB;
            wr_data_nxt = bus.AluData_i_WB;
          end
        end
      end
      WAIT_RSP: begin
        // a response in the final wait cycle beats the timeout
        if (bus.MemRspValid_i_WB) begin
          wr_en_nxt   = ld_wr_en && (ld_addr != '0);
          wr_addr_nxt = ld_addr;
          wr_data_nxt = extract(ld_funct3, ld_low, bus.MemRspData_i_WB);
          state_nxt   = IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.Ready_o_WB       = (state == IDLE);
  assign bus.WrEn_o_WB        = wr_en;
  assign bus.WrAddr_o_WB      = wr_addr;
  assign bus.WrData_o_WB      = wr_data;
  assign bus.fWB_Addr_o_WB    = wr_addr;
  assign bus.fWB_Data_o_WB    = wr_data;
  assign bus.LoadTimeout_o_WB = timeout;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
  logic        retire_evt;

  // x0 writes still retire; dropped loads do not
  assign retire_evt = ((state == IDLE) && bus.Valid_i_WB && !bus.IsLoad_i_WB) ||
                      ((state == WAIT_RSP) && bus.MemRspValid_i_WB);

  always_ff @(posedge clk_i_WB) begin
    if (Rst_i_WB) begin
      retire_cnt <= '0;
    end else if (retire_evt) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

  assign bus.RetireCnt_o_WB = retire_cnt;
`endif

endmodule

// File: tb/tb_wb_writer.sv
// Randomized self-checking bench for wb_writer against a transaction-level reference model.
module tb_wb_writer;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_writer_if #(.XLEN(XLEN), .REG_ADDR_W(AW)) bus ();

  wb_writer #(.XLEN(XLEN), .REG_ADDR_W(AW), .RSP_TIMEOUT(TMO)) dut (
    .clk_i_WB (clk),
    .Rst_i_WB (rst),
    .bus      (bus)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_data;
  int unsigned   m_retire;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference load extraction, written arithmetically
  function automatic logic [31:0] ref_ext(input int f3, input int low, input logic [31:0] word);
    logic [31:0] v;
    case (f3)
      0, 4: begin
        v = (word >> (8 * low)) & 32'hFF;
        if (f3 == 0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      1, 5: begin
        v = (word >> (16 * (low / 2))) & 32'hFFFF;
        if (f3 == 1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  task automatic chk_out(input string tag, input logic en);
    chk({tag, ".en"},   {31'd0, bus.WrEn_o_WB}, {31'd0, en});
    chk({tag, ".addr"}, {27'd0, bus.WrAddr_o_WB}, {27'd0, m_addr});
    chk({tag, ".data"}, bus.WrData_o_WB, m_data);
    chk({tag, ".faddr"}, {27'd0, bus.fWB_Addr_o_WB}, {27'd0, m_addr});
    chk({tag, ".fdata"}, bus.fWB_Data_o_WB, m_data);
    chk({tag, ".tmo"},  {31'd0, bus.LoadTimeout_o_WB}, 32'd0);
    chk({tag, ".rdy"},  {31'd0, bus.Ready_o_WB}, 32'd1);
`ifdef WB_RETIRE_CNT_EN
    chk({tag, ".retire"}, bus.RetireCnt_o_WB, m_retire);
`endif
  endtask

  task automatic do_alu(input logic we, input logic [AW-1:0] addr, input logic [31:0] data);
    bus.Valid_i_WB       = 1'b1;
    bus.IsLoad_i_WB      = 1'b0;
    bus.WrEn_i_WB        = we;
    bus.WrAddr_i_WB      = addr;
    bus.AluData_i_WB     = data;
    bus.LoadFunct3_i_WB  = 3'($urandom_range(0, 7));
    bus.LoadAddrLow_i_WB = 2'($urandom_range(0, 3));
    chk("alu.acc_rdy", {31'd0, bus.Ready_o_WB}, 32'd1);
    step();
    bus.Valid_i_WB = 1'b0;
    m_addr = addr;
    m_data = data;
    m_retire++;
    chk_out("alu", we && (addr != 0));
  endtask

  // delay >= TMO means no response is ever sent
  task automatic do_load(input logic we, input logic [AW-1:0] addr, input int f3,
                         input int low, input logic [31:0] word, input int delay);
    int n_wait;
    bus.Valid_i_WB       = 1'b1;
    bus.IsLoad_i_WB      = 1'b1;
    bus.WrEn_i_WB        = we;
    bus.WrAddr_i_WB      = addr;
    bus.AluData_i_WB     = $urandom;
    bus.LoadFunct3_i_WB  = 3'(f3);
    bus.LoadAddrLow_i_WB = 2'(low);
    chk("ld.acc_rdy", {31'd0, bus.Ready_o_WB}, 32'd1);
    step();
    bus.Valid_i_WB = 1'b0;
    n_wait = (delay < TMO) ? delay : TMO;
    for (int i = 0; i < n_wait; i++) begin
      chk("ld.wait_rdy", {31'd0, bus.Ready_o_WB}, 32'd0);
      chk("ld.wait_en",  {31'd0, bus.WrEn_o_WB}, 32'd0);
      chk("ld.wait_tmo", {31'd0, bus.LoadTimeout_o_WB}, 32'd0);
      if ($urandom_range(0, 3) == 0) bus.Valid_i_WB = 1'b1;
      step();
      bus.Valid_i_WB = 1'b0;
    end
    if (delay < TMO) begin
      chk("ld.rsp_rdy", {31'd0, bus.Ready_o_WB}, 32'd0);
      bus.MemRspValid_i_WB = 1'b1;
      bus.MemRspData_i_WB  = word;
      step();
      bus.MemRspValid_i_WB = 1'b0;
      bus.MemRspData_i_WB  = $urandom;
      m_addr = addr;
      m_data = ref_ext(f3, low, word);
      m_retire++;
      chk_out("ld", we && (addr != 0));
    end else begin
      chk("tmo.pulse", {31'd0, bus.LoadTimeout_o_WB}, 32'd1);
      chk("tmo.en",    {31'd0, bus.WrEn_o_WB}, 32'd0);
      chk("tmo.rdy",   {31'd0, bus.Ready_o_WB}, 32'd1);
      step();
      chk_out("tmo.after", 1'b0);
    end
  endtask

  task automatic stray_rsp();
    bus.MemRspValid_i_WB = 1'b1;
    bus.MemRspData_i_WB  = $urandom;
    step();
    bus.MemRspValid_i_WB = 1'b0;
    chk_out("stray", 1'b0);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
  endfunction

  initial begin
    rst = 1'b1;
    bus.Valid_i_WB = 1'b0; bus.IsLoad_i_WB = 1'b0; bus.WrEn_i_WB = 1'b0;
    bus.WrAddr_i_WB = '0; bus.AluData_i_WB = '0; bus.LoadFunct3_i_WB = '0;
    bus.LoadAddrLow_i_WB = '0; bus.MemRspValid_i_WB = 1'b0; bus.MemRspData_i_WB = '0;
    m_addr = '0; m_data = '0; m_retire = 0;
    step(); step();
    rst = 1'b0;
    chk_out("reset", 1'b0);

    do_alu(1'b1, 5'd5, 32'h0000_1234);
    step();
    chk_out("alu.pulse_end", 1'b0);
    do_alu(1'b1, 5'd0, 32'hDEAD_BEEF);

    do_load(1'b1, 5'd7, 0, 3, 32'h8000_0000, 3);
    chk("lb.val", bus.WrData_o_WB, 32'hFFFF_FF80);
    do_load(1'b1, 5'd7, 4, 3, 32'h8000_0000, 3);
    chk("lbu.val", bus.WrData_o_WB, 32'h0000_0080);
    do_load(1'b1, 5'd8, 1, 2, 32'h8001_7FFF, 1);
    chk("lh.val", bus.WrData_o_WB, 32'hFFFF_8001);
    do_load(1'b1, 5'd8, 5, 2, 32'h8001_7FFF, 0);
    chk("lhu.val", bus.WrData_o_WB, 32'h0000_8001);
    do_load(1'b1, 5'd9, 2, 2, 32'h8001_7FFF, 2);
    chk("lw.val", bus.WrData_o_WB, 32'h8001_7FFF);
    do_load(1'b1, 5'd10, 2, 0, 32'h1357_9BDF, TMO - 1);

    do_load(1'b1, 5'd11, 2, 0, 32'hCAFE_F00D, TMO);
    stray_rsp();

    // reset while a load is pending, then a late response
    bus.Valid_i_WB = 1'b1; bus.IsLoad_i_WB = 1'b1; bus.WrEn_i_WB = 1'b1;
    bus.WrAddr_i_WB = 5'd12; bus.LoadFunct3_i_WB = 3'd2;
    step();
    bus.Valid_i_WB = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_addr = '0; m_data = '0; m_retire = 0;
    chk_out("rst_wait", 1'b0);
    stray_rsp();

    do_alu(1'b1, 5'd1, 32'h1111_1111);
    do_alu(1'b1, 5'd2, 32'h2222_2222);
    do_alu(1'b1, 5'd3, 32'h3333_3333);
`ifdef WB_RETIRE_CNT_EN
    chk("retire3", bus.RetireCnt_o_WB, 32'd3);
`endif

    repeat (300) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5)
        do_alu($urandom_range(0, 3) != 0, rnd_addr(), $urandom);
      else if (r < 9)
        do_load($urandom_range(0, 3) != 0, rnd_addr(), $urandom_range(0, 7),
                $urandom_range(0, 3), $urandom, $urandom_range(0, TMO + 1));
      else
        stray_rsp();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
endmodule

// File: doc/wb_writer.md
Name: wb_writer

Overview:
- Writeback stage of the pipeline; the producer side of the register file write port (WrEn/WrAddr/WrData, written on the register file's negedge).
- Accepts retiring instructions from MEM with a valid/ready handshake.
- Waits for data-memory load responses, then extracts and sign/zero-extends the load data.
- Issues exactly one registered write pulse per retired rd-writing instruction and mirrors it on a forwarding bus.

Parameters:
XLEN, 32, data width of register file write data
REG_ADDR_W, 5, register address width
RSP_TIMEOUT, 16, max cycles in WAIT_RSP before the pending load is dropped (>=2)

Ports:
clk_i_WB  in  1  clock
Rst_i_WB  in  1  synchronous reset, active-high
Valid_i_WB  in  1  MEM presents a retiring instruction
Ready_o_WB  out  1  WB can accept; combinational, =1 only in IDLE
WrEn_i_WB  in  1  instruction writes rd
WrAddr_i_WB  in  REG_ADDR_W  rd
AluData_i_WB  in  XLEN  ALU/PC+4 result for non-loads
IsLoad_i_WB  in  1  instruction is a load
LoadFunct3_i_WB  in  3  load type (funct3)
LoadAddrLow_i_WB  in  2  load byte address [1:0]
MemRspValid_i_WB  in  1  data memory response valid (1-cycle pulse)
MemRspData_i_WB  in  XLEN  aligned 32-bit memory word
WrEn_o_WB  out  1  register file write enable
WrAddr_o_WB  out  REG_ADDR_W  register file write address
WrData_o_WB  out  XLEN  register file write data
fWB_Addr_o_WB  out  REG_ADDR_W  forwarding address (=WrAddr_o_WB)
fWB_Data_o_WB  out  XLEN  forwarding data (=WrData_o_WB)
LoadTimeout_o_WB  out  1  one-cycle pulse, pending load dropped

Behaviour:
- Reset values: state=IDLE, WrEn_o=0, WrAddr_o=0, WrData_o=0, LoadTimeout_o=0, timeout counter=0, held load info=0.
- Reset has priority over every event, including mid-WAIT_RSP: the pending load is dropped with no write.
- FSM states: IDLE, WAIT_RSP.
- IDLE, Valid&&Ready with IsLoad=0:
  - Next cycle, WrEn_o = WrEn_i && (WrAddr_i != 0), with WrAddr_o=WrAddr_i and WrData_o=AluData_i.
  - Latency is 1; back-to-back accepts give one write per cycle.
- IDLE, Valid&&Ready with IsLoad=1:
  - Capture WrEn, WrAddr, funct3 and addr low bits; go to WAIT_RSP and clear the counter.
  - No write pulse is issued that cycle.
- WAIT_RSP: Ready_o=0; the counter increments each cycle.
  - On MemRspValid, the extracted data is registered and WrEn_o pulses next cycle (if captured WrEn && addr!=0); go to IDLE.
  - WrEn_o is a pulse only: 0 in every cycle without a new write.
  - On the counter reaching RSP_TIMEOUT-1 with no response: go to IDLE, pulse LoadTimeout_o next cycle, no write.
  - If MemRspValid arrives in the same cycle as the timeout, the response wins and no timeout pulse is issued.
- MemRspValid while in IDLE is ignored (late response after timeout or reset).
- Load extraction (funct3):
  - 000 LB: byte[LoadAddrLow], sign-extended.
  - 100 LBU: byte[LoadAddrLow], zero-extended.
  - 001 LH: half[LoadAddrLow[1]], sign-extended.
  - 101 LHU: half[LoadAddrLow[1]], zero-extended.
  - 010 LW and all other codes: full word.
  - Misalignment is not checked here.
- x0 writes are never issued; WrAddr_o/WrData_o still update.
- WrAddr_o and WrData_o hold their last values when WrEn_o=0.
- Forwarding outputs are identical copies of the write outputs.

Optional Feature:
Macro WB_RETIRE_CNT_EN.
- Defined:
  - Adds output RetireCnt_o_WB [31:0], reset to 0.
  - Increments by 1 in the cycle after each accepted non-load and after each load completing via response, whether or not rd is written (x0 included).
  - Timeouts do not count; wraps 0xFFFFFFFF->0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset, then Valid=1, IsLoad=0, WrEn=1, WrAddr=5, AluData=0x0000_1234 -> next cycle WrEn_o=1, WrAddr_o=5, WrData_o=0x0000_1234; cycle after, WrEn_o=0.
- Non-load, WrAddr=0, AluData=0xDEAD_BEEF -> WrEn_o stays 0; Ready_o stays 1.
- LB, addr low=3, response 3 cycles later with 0x8000_0000 -> Ready_o=0 during wait; then WrData_o=0xFFFF_FF80, WrEn_o=1 one cycle. Same stimulus as LBU -> 0x0000_0080.
- LH, addr low=2, data 0x8001_7FFF -> 0xFFFF_8001; LHU -> 0x0000_8001; LW -> 0x8001_7FFF.
- Load with no response for 16 cycles -> LoadTimeout_o pulses once, no write, Ready_o=1. A response arriving 2 cycles later is ignored.
- Reset asserted in WAIT_RSP, then a response arrives -> no write. Three consecutive non-loads -> three consecutive WrEn_o pulses; RetireCnt_o_WB=3 with WB_RETIRE_CNT_EN defined.
